// File: rtl/push_scheduler.sv
// ---------------------------------------------------------------------------
// push_scheduler
//
// Cycle counter with a programmable wrap period that pushes NUM_CHANNELS
// processing lanes in sequence. Each lane gets a registered one-cycle pass
// pulse, staggered one cycle per lane. Completed rounds are counted, and the
// block stops in DONE after num_rounds rounds (0 = free-running).
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   enable      level run request; low returns the block to IDLE on the next edge
//   period      terminal count (counter runs 0..period), latched on IDLE->RUN
//   num_rounds  rounds before stopping, latched on IDLE->RUN; 0 = free-running
//   pass        one-hot per-channel push pulse, registered
//   count       current cycle count
//   round_cnt   completed rounds
//   round_done  one-cycle pulse on each wrap
//   busy        high while in RUN
//   done        high while in DONE
// ---------------------------------------------------------------------------
module push_scheduler #(
  parameter int NBITS_FOR_COUNTER = 3,
  parameter int NUM_CHANNELS      = 4,
  parameter int PASS_AT           = 1,
  parameter int RBITS             = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NBITS_FOR_COUNTER-1:0] period,
  input  logic [RBITS-1:0]             num_rounds,
  output logic [NUM_CHANNELS-1:0]      pass,
  output logic [NBITS_FOR_COUNTER-1:0] count,
  output logic [RBITS-1:0]             round_cnt,
  output logic                         round_done,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state, state_d;
  logic [NBITS_FOR_COUNTER-1:0] count_d;
  logic [RBITS-1:0]             round_cnt_d;
  logic [NUM_CHANNELS-1:0]      pass_d;
  logic                         round_done_d;
  logic [NBITS_FOR_COUNTER-1:0] period_q, period_d;
  logic [RBITS-1:0]             rounds_q, rounds_d;

  logic last_round;

  // The final round is only meaningful when a round limit was programmed.
  assign last_round = (rounds_q != '0) && (round_cnt == rounds_q - RBITS'(1));

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state;
    count_d      = count;
    round_cnt_d  = round_cnt;
    pass_d       = '0;
    round_done_d = 1'b0;
    period_d     = period_q;
    rounds_d     = rounds_q;

    if (!enable) begin
      // Dropping enable wins over everything and discards any pending pulse.
      state_d     = IDLE;
      count_d     = '0;
      round_cnt_d = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_d     = RUN;
          period_d    = period;
          rounds_d    = num_rounds;
          count_d     = '0;
          round_cnt_d = '0;
        end

        RUN: begin
          // Compare in integer width so a trigger value beyond the counter
          // range can never alias onto a small count.
          for (int k = 0; k < NUM_CHANNELS; k++) begin
            pass_d[k] = (int'(count) == PASS_AT + k);
          end

          if (count == period_q) begin
            count_d      = '0;
            round_done_d = 1'b1;
            if (last_round) begin
              round_cnt_d = rounds_q;
              state_d     = DONE;
            end else begin
              round_cnt_d = round_cnt + RBITS'(1);
            end
          end else begin
            count_d = count + NBITS_FOR_COUNTER'(1);
          end
        end

        DONE: begin
          // Parked: hold round_cnt until enable drops.
          count_d = '0;
        end

        default: begin
          state_d     = IDLE;
          count_d     = '0;
          round_cnt_d = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      round_cnt  <= '0;
      pass       <= '0;
      round_done <= 1'b0;
      period_q   <= '0;
      rounds_q   <= '0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      round_cnt  <= round_cnt_d;
      pass       <= pass_d;
      round_done <= round_done_d;
      period_q   <= period_d;
      rounds_q   <= rounds_d;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_push_scheduler.sv
// ---------------------------------------------------------------------------
// tb_push_scheduler
//
// Self-checking bench for push_scheduler with default parameters
// (3-bit counter, 4 channels, PASS_AT = 1, 4-bit round counter).
// A table of {inputs, expected outputs} vectors is applied one edge per entry,
// followed by hand-written sequences for multi-cycle corner cases.
// ---------------------------------------------------------------------------
module tb_push_scheduler;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] period;
  logic [3:0] num_rounds;
  logic [3:0] pass;
  logic [2:0] count;
  logic [3:0] round_cnt;
  logic       round_done;
  logic       busy;
  logic       done;

  int total;
  int bad;

  push_scheduler #(
    .NBITS_FOR_COUNTER(3),
    .NUM_CHANNELS     (4),
    .PASS_AT          (1),
    .RBITS            (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .period    (period),
    .num_rounds(num_rounds),
    .pass      (pass),
    .count     (count),
    .round_cnt (round_cnt),
    .round_done(round_done),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] per;
    logic [3:0] nr;
    logic [3:0] pass;
    logic [2:0] cnt;
    logic [3:0] rc;
    logic       rd;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic [2:0] per, logic [3:0] nr,
                              logic [3:0] p, logic [2:0] c, logic [3:0] rc,
                              logic rd, logic bsy, logic dn);
    vec_t v;
    v.en = en; v.per = per; v.nr = nr; v.pass = p; v.cnt = c;
    v.rc = rc; v.rd = rd; v.bsy = bsy; v.dn = dn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] p, input logic [2:0] c,
                           input logic [3:0] rc, input logic rd, input logic bsy,
                           input logic dn);
    check({tag, ".pass"},       32'(pass),       32'(p));
    check({tag, ".count"},      32'(count),      32'(c));
    check({tag, ".round_cnt"},  32'(round_cnt),  32'(rc));
    check({tag, ".round_done"}, 32'(round_done), 32'(rd));
    check({tag, ".busy"},       32'(busy),       32'(bsy));
    check({tag, ".done"},       32'(done),       32'(dn));
  endtask

  task automatic go_idle();
    enable = 1'b0;
    step();
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b0;
    enable     = 1'b0;
    period     = 3'd7;
    num_rounds = 4'd2;

    // ---------------- reset state ----------------
    #2;
    check_all("reset", 4'b0000, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- vector table ----------------
    // period=7, num_rounds=2: E0..E18 (fields: en per nr | pass cnt rc rd busy done)
    vecs.push_back(mk(1, 7, 2, 4'b0000, 0, 0, 0, 1, 0)); // E0
    vecs.push_back(mk(1, 7, 2, 4'b0000, 1, 0, 0, 1, 0)); // E1
    vecs.push_back(mk(1, 7, 2, 4'b0001, 2, 0, 0, 1, 0)); // E2
    vecs.push_back(mk(1, 7, 2, 4'b0010, 3, 0, 0, 1, 0)); // E3
    vecs.push_back(mk(1, 7, 2, 4'b0100, 4, 0, 0, 1, 0)); // E4
    vecs.push_back(mk(1, 7, 2, 4'b1000, 5, 0, 0, 1, 0)); // E5
    vecs.push_back(mk(1, 7, 2, 4'b0000, 6, 0, 0, 1, 0)); // E6
    vecs.push_back(mk(1, 7, 2, 4'b0000, 7, 0, 0, 1, 0)); // E7
    vecs.push_back(mk(1, 7, 2, 4'b0000, 0, 1, 1, 1, 0)); // E8 wrap
    vecs.push_back(mk(1, 7, 2, 4'b0000, 1, 1, 0, 1, 0)); // E9
    vecs.push_back(mk(1, 7, 2, 4'b0001, 2, 1, 0, 1, 0)); // E10
    vecs.push_back(mk(1, 7, 2, 4'b0010, 3, 1, 0, 1, 0)); // E11
    vecs.push_back(mk(1, 7, 2, 4'b0100, 4, 1, 0, 1, 0)); // E12
    vecs.push_back(mk(1, 7, 2, 4'b1000, 5, 1, 0, 1, 0)); // E13
    vecs.push_back(mk(1, 7, 2, 4'b0000, 6, 1, 0, 1, 0)); // E14
    vecs.push_back(mk(1, 7, 2, 4'b0000, 7, 1, 0, 1, 0)); // E15
    vecs.push_back(mk(1, 7, 2, 4'b0000, 0, 2, 1, 0, 1)); // E16 final wrap -> DONE
    vecs.push_back(mk(1, 7, 2, 4'b0000, 0, 2, 0, 0, 1)); // E17 hold
    vecs.push_back(mk(1, 2, 5, 4'b0000, 0, 2, 0, 0, 1)); // E18 hold, inputs ignored
    vecs.push_back(mk(0, 2, 0, 4'b0000, 0, 0, 0, 0, 0)); // back to IDLE
    // period=2, free-running: only pass[0] and pass[1] fire
    vecs.push_back(mk(1, 2, 0, 4'b0000, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2, 0, 4'b0000, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2, 0, 4'b0001, 2, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2, 0, 4'b0010, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 2, 0, 4'b0000, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 2, 0, 4'b0001, 2, 1, 0, 1, 0));
    vecs.push_back(mk(1, 2, 0, 4'b0010, 0, 2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    // period=0, free-running: wrap every cycle, round_done held high
    vecs.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 0, 2, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 0, 3, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 0, 0, 0, 0, 0));
    // period=0, one round: DONE after the first wrap
    vecs.push_back(mk(1, 0, 1, 4'b0000, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 4'b0000, 0, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 4'b0000, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      enable     = vecs[i].en;
      period     = vecs[i].per;
      num_rounds = vecs[i].nr;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].pass, vecs[i].cnt, vecs[i].rc,
                vecs[i].rd, vecs[i].bsy, vecs[i].dn);
    end

    // ---------------- drop enable at count=4 ----------------
    go_idle();
    period     = 3'd7;
    num_rounds = 4'd2;
    enable     = 1'b1;
    step();                               // E0
    for (int i = 0; i < 4; i++) step();   // E1..E4
    check("drop.pre_count", 32'(count), 32'd4);
    enable = 1'b0;                        // pass[3] would have fired at this edge
    step();
    check_all("drop.after", 4'b0000, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    step();                               // new E0
    check_all("drop.reE0", 4'b0000, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    step();                               // new E2
    check_all("drop.reE2", 4'b0001, 3'd2, 4'd0, 1'b0, 1'b1, 1'b0);

    // ---------------- period change mid-RUN ----------------
    go_idle();
    period     = 3'd7;
    num_rounds = 4'd0;
    enable     = 1'b1;
    step();                               // E0
    for (int i = 0; i < 3; i++) step();   // E1..E3
    period = 3'd2;
    for (int i = 0; i < 4; i++) step();   // E4..E7
    check("perchg.count7", 32'(count), 32'd7);
    check("perchg.no_wrap", 32'(round_cnt), 32'd0);
    step();                               // E8 wrap at old period
    check("perchg.wrap_count", 32'(count), 32'd0);
    check("perchg.wrap_rd", 32'(round_done), 32'd1);
    go_idle();
    enable = 1'b1;
    step();                               // re-entry latches period=2
    step();
    step();
    check("perchg.new_count2", 32'(count), 32'd2);
    step();
    check("perchg.new_wrap_count", 32'(count), 32'd0);
    check("perchg.new_wrap_rd", 32'(round_done), 32'd1);

    // ---------------- round counter wrap, free-running ----------------
    go_idle();
    period     = 3'd3;
    num_rounds = 4'd0;
    enable     = 1'b1;
    step();                               // E0
    for (int j = 1; j <= 70; j++) begin
      step();
      check($sformatf("wrap.e%0d.count", j), 32'(count), 32'(j % 4));
      check($sformatf("wrap.e%0d.rd", j), 32'(round_done), 32'((j % 4) == 0));
      check($sformatf("wrap.e%0d.rc", j), 32'(round_cnt), 32'((j / 4) % 16));
      check($sformatf("wrap.e%0d.done", j), 32'(done), 32'd0);
    end

    // ---------------- async reset mid-RUN ----------------
    go_idle();
    period     = 3'd7;
    num_rounds = 4'd2;
    enable     = 1'b1;
    step();                               // E0
    for (int i = 0; i < 5; i++) step();   // E5: pass=1000
    check("areset.pre_pass", 32'(pass), 32'b1000);
    #2;                                   // between edges
    reset = 1'b0;
    #1;
    check_all("areset.now", 4'b0000, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step();                               // E0 after release
    check_all("areset.E0", 4'b0000, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    check_all("areset.E2", 4'b0001, 3'd2, 4'd0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
